util_gmii_rate_adapter: RTL and testbench
=========================================

Name: util_gmii_rate_adapter

Overview:
- Single-clock (125 MHz) GMII rate adapter for 10/100/1000 Ethernet. Sits between the MAC's byte-wide GMII port and the SDR side of the RGMII DDR I/O wrapper.
- At 1000 Mb/s it is a registered pass-through.
- At 100/10 Mb/s it splits TX bytes into nibbles, assembles RX nibbles into SFD-aligned bytes, and paces both sides with clock-enable strobes.
- Generates half-duplex CRS/COL.

Parameters:
- CLK_DIV_100, 5, clk cycles per nibble at 100 Mb/s (125 MHz / 25 MHz).
- CLK_DIV_10, 50, clk cycles per nibble at 10 Mb/s.
- RX_ERR_ON_MISALIGN, 1, when 1 a non-preamble nibble before SFD drops the frame and pulses rx_align_err.

Ports:
- clk  in  1  single clock, 125 MHz.
- reset_n  in  1  synchronous, active-low reset.
- speed_selection  in  2  1x = gigabit, 01 = 100 Mb/s, 00 = 10 Mb/s.
- duplex_mode  in  1  1 = full, 0 = half.
- mac_txd  in  8  TX byte from MAC.
- mac_tx_en  in  1  TX enable from MAC.
- mac_tx_er  in  1  TX error from MAC.
- mac_tx_ce  out  1  byte accept strobe; byte is taken in the cycle this is high.
- phy_txd  out  8  gigabit: byte; 10/100: nibble on [3:0], replicated on [7:4].
- phy_tx_en  out  1  TX enable to PHY side.
- phy_tx_er  out  1  TX error to PHY side.
- phy_tx_ce  out  1  qualifies phy_tx*.
- phy_rxd  in  8  gigabit: byte; 10/100: nibble on [3:0].
- phy_rx_dv  in  1  RX data valid from PHY side.
- phy_rx_er  in  1  RX error from PHY side.
- phy_rx_ce  in  1  qualifies phy_rx*.
- mac_rxd  out  8  RX byte to MAC.
- mac_rx_dv  out  1  RX data valid to MAC.
- mac_rx_er  out  1  RX error to MAC.
- mac_rx_ce  out  1  qualifies mac_rx*.
- mac_crs  out  1  carrier sense.
- mac_col  out  1  collision.
- rx_align_err  out  1  one-cycle pulse on RX alignment fault.

Behaviour:
- Reset: while reset_n = 0 at a clk edge, all outputs go to 0, both FSMs go to IDLE, the strobe counter clears, and speed_q latches speed_selection.
- Speed latch: speed_q and duplex_q update only when TX FSM = IDLE and RX FSM = IDLE and phy_tx_en = 0 and phy_rx_dv = 0. Speed changes mid-frame take effect after the frame ends.
- Strobe generator:
  - Gigabit: nib_stb = 1 every cycle.
  - Otherwise: counter 0..DIV-1 with DIV = CLK_DIV_100 or CLK_DIV_10; nib_stb = 1 when the counter = DIV-1.
  - Counter restarts at 0 on any speed_q change.
- TX gigabit:
  - mac_tx_ce = 1 constantly.
  - phy_txd/en/er are mac_* registered: 1-cycle latency. phy_tx_ce = 1.
- TX 10/100 FSM, states IDLE, LO, HI:
  - mac_tx_ce = nib_stb in IDLE or HI; byte is captured on that cycle.
  - Next cycle: phy_txd = {lo,lo}, phy_tx_en/er = captured values, phy_tx_ce = 1 for one cycle, state = LO.
  - On the next nib_stb: phy_txd = {hi,hi} with phy_tx_ce pulse, state = HI.
  - Return to IDLE when a captured mac_tx_en = 0.
  - mac_tx_er is carried on both nibbles of its byte.
  - phy_tx_ce = 0 on all other cycles.
- RX gigabit: mac_rx* = phy_rx* registered when phy_rx_ce = 1; mac_rx_ce = phy_rx_ce delayed 1 cycle.
- RX 10/100 FSM, states IDLE, HUNT, LO, HI, DROP; all transitions only on phy_rx_ce = 1:
  - IDLE -> HUNT on phy_rx_dv = 1.
  - HUNT, nibble 0x5: stay; set seen5.
  - HUNT, nibble 0xD with seen5 = 1: emit 0xD5 with mac_rx_dv = 1; -> LO.
  - HUNT, any other nibble (or 0xD without seen5), RX_ERR_ON_MISALIGN = 1: rx_align_err pulse; -> DROP.
  - Preamble nibbles are not forwarded. The MAC sees SFD as the first dv byte.
  - LO: store nibble as low; -> HI.
  - HI: emit {nibble, low} with mac_rx_ce pulse; mac_rx_er = OR of er over both nibbles; -> LO.
  - phy_rx_dv = 0 in LO: clean end; emit a dv = 0 byte with ce; -> IDLE.
  - phy_rx_dv = 0 in HI: half byte discarded; rx_align_err pulse; dv = 0 byte emitted; -> IDLE.
  - DROP: hold until phy_rx_dv = 0, emitting nothing; -> IDLE.
- CRS/COL, registered from phy side:
  - duplex_q = 1: mac_crs = mac_col = 0.
  - Otherwise: crs = phy_tx_en | phy_rx_dv; col = phy_tx_en & phy_rx_dv.
- Reset mid-frame: frame is aborted and outputs clear on the same edge. No partial byte is emitted after reset release.

Decomposition:
- Package util_gmii_pkg holds:
  - SPEED_10 / SPEED_100 / SPEED_1000 encodings.
  - NIB_PRE = 4'h5, NIB_SFD = 4'hD, BYTE_SFD = 8'hD5.
  - TX and RX state enumerations.
- One sub-module, util_gmii_ce_gen: strobe counter with DIV selection and restart on speed change.

Test Plan:
- Gigabit, 64-byte frame 0x00..0x3F on mac_tx -> identical bytes on phy_txd, 1 cycle later; mac_tx_ce constantly 1.
- 100 Mb/s, TX byte 0xA5 -> phy_txd 0x55 then 0xAA, phy_tx_ce pulses exactly 5 cycles apart; mac_tx_ce period 10 cycles.
- 10 Mb/s RX: nibbles 5×15, D, then 3,1,2,4 -> mac_rxd D5, 13, 42; then a dv = 0 byte; no rx_align_err.
- 100 Mb/s RX: preamble then nibble 0x7 before SFD -> rx_align_err single pulse; no mac_rx_dv for that frame; next good frame received normally.
- Half duplex, overlapping phy_tx_en and phy_rx_dv -> mac_col = 1 during overlap, mac_crs = 1 during union; full duplex -> both 0.
- speed_selection changed 10 -> 1x mid-frame -> frame completes at 10 Mb/s; gigabit timing from next frame. Reset_n low mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/util_gmii_pkg.sv
// Shared encodings and state types for the GMII 10/100/1000 rate adapter.
package util_gmii_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  localparam logic [3:0] NIB_PRE  = 4'h5;
  localparam logic [3:0] NIB_SFD  = 4'hD;
  localparam logic [7:0] BYTE_SFD = 8'hD5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LO,
    TX_HI
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_HUNT,
    RX_LO,
    RX_HI,
    RX_DROP
  } rx_state_t;

  // Any encoding with the top bit set selects gigabit.
  function automatic logic is_gig(input logic [1:0] speed);
    return (speed & SPEED_1000) != 2'b00;
  endfunction

endpackage

// File: rtl/util_gmii_rate_adapter_ce_gen.sv
// Nibble-rate strobe: every cycle at gigabit, once per DIV cycles at 10/100.
module util_gmii_ce_gen
  import util_gmii_pkg::*;
#(
  parameter int unsigned CLK_DIV_100 = 5,
  parameter int unsigned CLK_DIV_10  = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] speed,
  output logic       nib_stb
);

  localparam int unsigned DIV_MAX = (CLK_DIV_10 > CLK_DIV_100) ? CLK_DIV_10 : CLK_DIV_100;
  localparam int unsigned CW      = $clog2(DIV_MAX);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div_last;
  logic [1:0]    speed_prev;
  logic          restart;

  always_comb begin
    case (speed)
      SPEED_10:  div_last = CW'(CLK_DIV_10 - 1);
      SPEED_100: div_last = CW'(CLK_DIV_100 - 1);
      default:   div_last = CW'(CLK_DIV_10 - 1);
    endcase
    restart = (speed != speed_prev);
    if (is_gig(speed)) begin
      nib_stb = 1'b1;
    end else begin
      // A stale count must not fire a strobe in the cycle the rate changes.
      nib_stb = !restart && (cnt == div_last);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      speed_prev <= speed;
    end else begin
      speed_prev <= speed;
      if (restart || is_gig(speed) || (cnt == div_last)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/util_gmii_rate_adapter.sv
// GMII rate adapter: gigabit pass-through, or nibble split/assemble with
// strobe pacing at 10/100, plus half-duplex CRS/COL generation.
module util_gmii_rate_adapter
  import util_gmii_pkg::*;
#(
  parameter int unsigned CLK_DIV_100        = 5,
  parameter int unsigned CLK_DIV_10         = 50,
  parameter bit          RX_ERR_ON_MISALIGN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] speed_selection,
  input  logic       duplex_mode,
  input  logic [7:0] mac_txd,
  input  logic       mac_tx_en,
  input  logic       mac_tx_er,
  output logic       mac_tx_ce,
  output logic [7:0] phy_txd,
  output logic       phy_tx_en,
  output logic       phy_tx_er,
  output logic       phy_tx_ce,
  input  logic [7:0] phy_rxd,
  input  logic       phy_rx_dv,
  input  logic       phy_rx_er,
  input  logic       phy_rx_ce,
  output logic [7:0] mac_rxd,
  output logic       mac_rx_dv,
  output logic       mac_rx_er,
  output logic       mac_rx_ce,
  output logic       mac_crs,
  output logic       mac_col,
  output logic       rx_align_err
);

  logic [1:0] speed_q;
  logic       duplex_q;
  logic       active;
  logic       gig;
  logic       nib_stb;
  tx_state_t  tx_state;
  rx_state_t  rx_state;
  logic [3:0] tx_hi;
  logic [3:0] rx_lo;
  logic       rx_er_lo;
  logic       seen5;
  logic [3:0] rx_nib;

  assign gig    = is_gig(speed_q);
  assign rx_nib = phy_rxd[3:0];

  util_gmii_ce_gen #(
    .CLK_DIV_100 (CLK_DIV_100),
    .CLK_DIV_10  (CLK_DIV_10)
  ) u_ce_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .speed   (speed_q),
    .nib_stb (nib_stb)
  );

  // active keeps the combinational accept strobe low through reset.
  assign mac_tx_ce = active && nib_stb && (gig || (tx_state != TX_LO));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active   <= 1'b0;
      speed_q  <= speed_selection;
      duplex_q <= duplex_mode;
      mac_crs  <= 1'b0;
      mac_col  <= 1'b0;
    end else begin
      active <= 1'b1;
      if ((tx_state == TX_IDLE) && (rx_state == RX_IDLE) && !phy_tx_en && !phy_rx_dv) begin
        speed_q  <= speed_selection;
        duplex_q <= duplex_mode;
      end
      if (duplex_q) begin
        mac_crs <= 1'b0;
        mac_col <= 1'b0;
      end else begin
        mac_crs <= phy_tx_en | phy_rx_dv;
        mac_col <= phy_tx_en & phy_rx_dv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state  <= TX_IDLE;
      tx_hi     <= '0;
      phy_txd   <= '0;
      phy_tx_en <= 1'b0;
      phy_tx_er <= 1'b0;
      phy_tx_ce <= 1'b0;
    end else if (gig) begin
      tx_state  <= TX_IDLE;
      phy_txd   <= mac_txd;
      phy_tx_en <= mac_tx_en;
      phy_tx_er <= mac_tx_er;
      phy_tx_ce <= 1'b1;
    end else begin
      phy_tx_ce <= 1'b0;
      case (tx_state)
        TX_IDLE, TX_HI: begin
          if (mac_tx_ce) begin
            phy_txd   <= {2{mac_txd[3:0]}};
            phy_tx_en <= mac_tx_en;
            phy_tx_er <= mac_tx_er;
            phy_tx_ce <= 1'b1;
            tx_hi     <= mac_txd[7:4];
            tx_state  <= mac_tx_en ? TX_LO : TX_IDLE;
          end
        end
        TX_LO: begin
          if (nib_stb) begin
            phy_txd   <= {2{tx_hi}};
            phy_tx_ce <= 1'b1;
            tx_state  <= TX_HI;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state     <= RX_IDLE;
      rx_lo        <= '0;
      rx_er_lo     <= 1'b0;
      seen5        <= 1'b0;
      mac_rxd      <= '0;
      mac_rx_dv    <= 1'b0;
      mac_rx_er    <= 1'b0;
      mac_rx_ce    <= 1'b0;
      rx_align_err <= 1'b0;
    end else if (gig) begin
      rx_state     <= RX_IDLE;
      mac_rx_ce    <= phy_rx_ce;
      rx_align_err <= 1'b0;
      if (phy_rx_ce) begin
        mac_rxd   <= phy_rxd;
        mac_rx_dv <= phy_rx_dv;
        mac_rx_er <= phy_rx_er;
      end
    end else begin
      mac_rx_ce    <= 1'b0;
      rx_align_err <= 1'b0;
      if (phy_rx_ce) begin
        case (rx_state)
          RX_IDLE: begin
            if (phy_rx_dv) begin
              rx_state <= RX_HUNT;
              seen5    <= (rx_nib == NIB_PRE);
            end
          end
          RX_HUNT: begin
            if (!phy_rx_dv) begin
              rx_state <= RX_IDLE;
            end else if (rx_nib == NIB_PRE) begin
              seen5 <= 1'b1;
            end else if ((rx_nib == NIB_SFD) && seen5) begin
              mac_rxd   <= BYTE_SFD;
              mac_rx_dv <= 1'b1;
              mac_rx_er <= phy_rx_er;
              mac_rx_ce <= 1'b1;
              rx_state  <= RX_LO;
            end else if (RX_ERR_ON_MISALIGN) begin
              rx_align_err <= 1'b1;
              rx_state     <= RX_DROP;
            end else begin
              seen5 <= 1'b0;
            end
          end
          RX_LO: begin
            if (!phy_rx_dv) begin
              mac_rxd   <= '0;
              mac_rx_dv <= 1'b0;
              mac_rx_er <= 1'b0;
              mac_rx_ce <= 1'b1;
              rx_state  <= RX_IDLE;
            end else begin
              rx_lo    <= rx_nib;
              rx_er_lo <= phy_rx_er;
              rx_state <= RX_HI;
            end
          end
          RX_HI: begin
            if (!phy_rx_dv) begin
              // Odd nibble count: the stored half byte is discarded.
              rx_align_err <= 1'b1;
              mac_rxd      <= '0;
              mac_rx_dv    <= 1'b0;
              mac_rx_er    <= 1'b0;
              mac_rx_ce    <= 1'b1;
              rx_state     <= RX_IDLE;
            end else begin
              mac_rxd   <= {rx_nib, rx_lo};
              mac_rx_dv <= 1'b1;
              mac_rx_er <= rx_er_lo | phy_rx_er;
              mac_rx_ce <= 1'b1;
              rx_state  <= RX_LO;
            end
          end
          RX_DROP: begin
            if (!phy_rx_dv) rx_state <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_util_gmii_rate_adapter.sv
// Directed self-checking bench for util_gmii_rate_adapter.
module tb_util_gmii_rate_adapter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] speed_selection;
  logic       duplex_mode;
  logic [7:0] mac_txd;
  logic       mac_tx_en;
  logic       mac_tx_er;
  logic       mac_tx_ce;
  logic [7:0] phy_txd;
  logic       phy_tx_en;
  logic       phy_tx_er;
  logic       phy_tx_ce;
  logic [7:0] phy_rxd;
  logic       phy_rx_dv;
  logic       phy_rx_er;
  logic       phy_rx_ce;
  logic [7:0] mac_rxd;
  logic       mac_rx_dv;
  logic       mac_rx_er;
  logic       mac_rx_ce;
  logic       mac_crs;
  logic       mac_col;
  logic       rx_align_err;

  int unsigned pass_cnt  = 0;
  int unsigned check_cnt = 0;

  logic [9:0]  rx_log [0:1023];
  int unsigned rx_cnt    = 0;
  int unsigned align_cnt = 0;

  logic [25:0] all_outs;
  assign all_outs = {mac_tx_ce, phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce,
                     mac_rxd, mac_rx_dv, mac_rx_er, mac_rx_ce, mac_crs, mac_col, rx_align_err};

  util_gmii_rate_adapter #(
    .CLK_DIV_100        (5),
    .CLK_DIV_10         (50),
    .RX_ERR_ON_MISALIGN (1'b1)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .speed_selection (speed_selection),
    .duplex_mode     (duplex_mode),
    .mac_txd         (mac_txd),
    .mac_tx_en       (mac_tx_en),
    .mac_tx_er       (mac_tx_er),
    .mac_tx_ce       (mac_tx_ce),
    .phy_txd         (phy_txd),
    .phy_tx_en       (phy_tx_en),
    .phy_tx_er       (phy_tx_er),
    .phy_tx_ce       (phy_tx_ce),
    .phy_rxd         (phy_rxd),
    .phy_rx_dv       (phy_rx_dv),
    .phy_rx_er       (phy_rx_er),
    .phy_rx_ce       (phy_rx_ce),
    .mac_rxd         (mac_rxd),
    .mac_rx_dv       (mac_rx_dv),
    .mac_rx_er       (mac_rx_er),
    .mac_rx_ce       (mac_rx_ce),
    .mac_crs         (mac_crs),
    .mac_col         (mac_col),
    .rx_align_err    (rx_align_err)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (mac_rx_ce === 1'b1) begin
      rx_log[rx_cnt % 1024] = {mac_rx_dv, mac_rx_er, mac_rxd};
      rx_cnt = rx_cnt + 1;
    end
    if (rx_align_err === 1'b1) align_cnt = align_cnt + 1;
  end

  task automatic send_nib(input logic [3:0] n, input logic dv, input logic er);
    @(negedge clk);
    phy_rxd   = {4'h0, n};
    phy_rx_dv = dv;
    phy_rx_er = er;
    phy_rx_ce = 1'b1;
    @(negedge clk);
    phy_rx_ce = 1'b0;
    phy_rx_er = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    speed_selection = 2'b10;
    duplex_mode = 1'b1;
    mac_txd = '0; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
    phy_rxd = '0; phy_rx_dv = 1'b0; phy_rx_er = 1'b0; phy_rx_ce = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (all_outs !== 26'h0) $display("FAIL reset_outputs: got %h want 0", all_outs);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (mac_tx_ce !== 1'b1) $display("FAIL gig_tx_ce_after_reset: got %b want 1", mac_tx_ce);
    else pass_cnt++;
  endtask

  task automatic test_gig_tx;
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_cnt++;
        if ({phy_txd, phy_tx_en, phy_tx_ce} !== {8'(i - 1), 1'b1, 1'b1})
          $display("FAIL gig_tx_byte[%0d]: got txd=%h en=%b ce=%b want txd=%h en=1 ce=1",
                   i - 1, phy_txd, phy_tx_en, phy_tx_ce, 8'(i - 1));
        else pass_cnt++;
      end
      check_cnt++;
      if (mac_tx_ce !== 1'b1) $display("FAIL gig_mac_tx_ce[%0d]: got %b want 1", i, mac_tx_ce);
      else pass_cnt++;
      if (i < 64) begin mac_txd = 8'(i); mac_tx_en = 1'b1; end
      else mac_tx_en = 1'b0;
    end
    @(negedge clk);
    check_cnt++;
    if (phy_tx_en !== 1'b0) $display("FAIL gig_tx_end: got en=%b want 0", phy_tx_en);
    else pass_cnt++;
  endtask

  task automatic test_half_duplex;
    logic exp_crs, exp_col;
    for (int pass = 0; pass < 2; pass++) begin
      duplex_mode = (pass == 1);
      repeat (4) @(negedge clk);
      for (int j = 0; j < 12; j++) begin
        if (pass == 0) begin
          exp_crs = (j >= 2 && j <= 8);
          exp_col = (j >= 4 && j <= 6);
        end else begin
          exp_crs = 1'b0;
          exp_col = 1'b0;
        end
        check_cnt++;
        if ({mac_crs, mac_col} !== {exp_crs, exp_col})
          $display("FAIL crs_col[dup=%0d,t=%0d]: got crs=%b col=%b want crs=%b col=%b",
                   pass, j, mac_crs, mac_col, exp_crs, exp_col);
        else pass_cnt++;
        mac_tx_en = (j <= 4);
        phy_rx_dv = (j >= 3 && j <= 7);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_tx_100;
    logic found;
    speed_selection = 2'b01;
    mac_tx_en = 1'b0;
    repeat (4) @(negedge clk);
    mac_txd = 8'hA5; mac_tx_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mac_tx_ce === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check_cnt++;
    if (!found) $display("FAIL tx100_accept_timeout: got no mac_tx_ce want one within 20 cycles");
    else pass_cnt++;
    @(posedge clk);
    #1;
    mac_txd = 8'h00; mac_tx_en = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check_cnt++;
      if (phy_tx_ce !== (c == 1 || c == 6 || c == 11))
        $display("FAIL tx100_phy_ce[%0d]: got %b want %b", c, phy_tx_ce, (c == 1 || c == 6 || c == 11));
      else pass_cnt++;
      check_cnt++;
      if (mac_tx_ce !== (c == 10))
        $display("FAIL tx100_mac_ce[%0d]: got %b want %b", c, mac_tx_ce, (c == 10));
      else pass_cnt++;
      if (c == 1 || c == 6) begin
        check_cnt++;
        if ({phy_txd, phy_tx_en} !== {((c == 1) ? 8'h55 : 8'hAA), 1'b1})
          $display("FAIL tx100_nibble[%0d]: got txd=%h en=%b want txd=%h en=1",
                   c, phy_txd, phy_tx_en, (c == 1) ? 8'h55 : 8'hAA);
        else pass_cnt++;
      end
      if (c == 11) begin
        check_cnt++;
        if (phy_tx_en !== 1'b0) $display("FAIL tx100_end: got en=%b want 0", phy_tx_en);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_rx_10;
    int unsigned base, abase;
    speed_selection = 2'b00;
    repeat (4) @(negedge clk);
    base = rx_cnt; abase = align_cnt;
    for (int i = 0; i < 15; i++) send_nib(4'h5, 1'b1, 1'b0);
    send_nib(4'hD, 1'b1, 1'b0);
    send_nib(4'h3, 1'b1, 1'b0);
    send_nib(4'h1, 1'b1, 1'b0);
    send_nib(4'h2, 1'b1, 1'b0);
    send_nib(4'h4, 1'b1, 1'b0);
    send_nib(4'h0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_cnt++;
    if (rx_cnt - base !== 4) $display("FAIL rx10_count: got %0d want 4", rx_cnt - base);
    else pass_cnt++;
    check_cnt++;
    if (rx_log[base % 1024] !== 10'h2D5) $display("FAIL rx10_sfd: got %h want 2d5", rx_log[base % 1024]);
    else pass_cnt++;
    check_cnt++;
    if (rx_log[(base + 1) % 1024] !== 10'h213) $display("FAIL rx10_b1: got %h want 213", rx_log[(base + 1) % 1024]);
    else pass_cnt++;
    check_cnt++;
    if (rx_log[(base + 2) % 1024] !== 10'h242) $display("FAIL rx10_b2: got %h want 242", rx_log[(base + 2) % 1024]);
    else pass_cnt++;
    check_cnt++;
    if (rx_log[(base + 3) % 1024][9] !== 1'b0) $display("FAIL rx10_end_dv: got %b want 0", rx_log[(base + 3) % 1024][9]);
    else pass_cnt++;
    check_cnt++;
    if (align_cnt - abase !== 0) $display("FAIL rx10_align: got %0d want 0", align_cnt - abase);
    else pass_cnt++;
  endtask

  task automatic test_rx_100_misalign;
    int unsigned base, abase;
    logic [3:0] bad_frame [0:8];
    bad_frame = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h7, 4'h5, 4'hD, 4'h1, 4'h2};
    speed_selection = 2'b01;
    repeat (4) @(negedge clk);
    base = rx_cnt; abase = align_cnt;
    for (int i = 0; i < 9; i++) send_nib(bad_frame[i], 1'b1, 1'b0);
    send_nib(4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_cnt++;
    if (rx_cnt - base !== 0) $display("FAIL misalign_bytes: got %0d want 0", rx_cnt - base);
    else pass_cnt++;
    check_cnt++;
    if (align_cnt - abase !== 1) $display("FAIL misalign_pulse: got %0d cycles want 1", align_cnt - abase);
    else pass_cnt++;
    base = rx_cnt; abase = align_cnt;
    for (int i = 0; i < 3; i++) send_nib(4'h5, 1'b1, 1'b0);
    send_nib(4'hD, 1'b1, 1'b0);
    send_nib(4'hE, 1'b1, 1'b0);
    send_nib(4'hB, 1'b1, 1'b1);
    send_nib(4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({rx_cnt - base, align_cnt - abase} !== {32'd3, 32'd0})
      $display("FAIL good_after_drop_counts: got bytes=%0d align=%0d want bytes=3 align=0", rx_cnt - base, align_cnt - abase);
    else pass_cnt++;
    check_cnt++;
    if ({rx_log[base % 1024], rx_log[(base + 1) % 1024], rx_log[(base + 2) % 1024][9]} !== {10'h2D5, 10'h3BE, 1'b0})
      $display("FAIL good_after_drop_data: got %h %h dv=%b want 2d5 3be dv=0",
               rx_log[base % 1024], rx_log[(base + 1) % 1024], rx_log[(base + 2) % 1024][9]);
    else pass_cnt++;
    base = rx_cnt; abase = align_cnt;
    send_nib(4'h5, 1'b1, 1'b0);
    send_nib(4'hD, 1'b1, 1'b0);
    send_nib(4'h1, 1'b1, 1'b0);
    send_nib(4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({rx_cnt - base, align_cnt - abase} !== {32'd2, 32'd1})
      $display("FAIL half_byte_abort: got bytes=%0d align=%0d want bytes=2 align=1", rx_cnt - base, align_cnt - abase);
    else pass_cnt++;
    check_cnt++;
    if ({rx_log[base % 1024], rx_log[(base + 1) % 1024][9]} !== {10'h2D5, 1'b0})
      $display("FAIL half_byte_data: got %h dv=%b want 2d5 dv=0", rx_log[base % 1024], rx_log[(base + 1) % 1024][9]);
    else pass_cnt++;
  endtask

  task automatic test_speed_change;
    logic found;
    int   seen_at;
    speed_selection = 2'b00;
    repeat (4) @(negedge clk);
    mac_txd = 8'h12; mac_tx_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 120 && !found; k++) begin
      if (mac_tx_ce === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check_cnt++;
    if (!found) $display("FAIL spd_accept_timeout: got no mac_tx_ce want one within 120 cycles");
    else pass_cnt++;
    @(posedge clk);
    #1;
    mac_txd = 8'h00; mac_tx_en = 1'b0;
    @(negedge clk);
    speed_selection = 2'b10;
    check_cnt++;
    if ({phy_txd, phy_tx_ce} !== {8'h22, 1'b1}) $display("FAIL spd_lo: got txd=%h ce=%b want 22 1", phy_txd, phy_tx_ce);
    else pass_cnt++;
    seen_at = 0;
    for (int c = 2; c <= 150 && seen_at == 0; c++) begin
      @(negedge clk);
      if (c == 51) begin
        check_cnt++;
        if ({phy_txd, phy_tx_ce} !== {8'h11, 1'b1}) $display("FAIL spd_hi: got txd=%h ce=%b want 11 1", phy_txd, phy_tx_ce);
        else pass_cnt++;
      end
      if (mac_tx_ce === 1'b1) seen_at = c;
    end
    check_cnt++;
    if (seen_at != 100) $display("FAIL spd_next_accept: got cycle %0d want 100", seen_at);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    check_cnt++;
    if (mac_tx_ce !== 1'b1) $display("FAIL spd_gig_ce: got %b want 1", mac_tx_ce);
    else pass_cnt++;
    mac_txd = 8'h77; mac_tx_en = 1'b1;
    @(negedge clk);
    mac_tx_en = 1'b0;
    check_cnt++;
    if ({phy_txd, phy_tx_en, phy_tx_ce} !== {8'h77, 1'b1, 1'b1})
      $display("FAIL spd_gig_pass: got txd=%h en=%b ce=%b want 77 1 1", phy_txd, phy_tx_en, phy_tx_ce);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int unsigned base;
    duplex_mode = 1'b0;
    repeat (4) @(negedge clk);
    mac_txd = 8'h3C; mac_tx_en = 1'b1;
    phy_rxd = 8'h81; phy_rx_dv = 1'b1; phy_rx_ce = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({mac_crs, mac_col, mac_rx_dv, phy_tx_en} !== 4'b1111)
      $display("FAIL pre_reset_activity: got %b want 1111", {mac_crs, mac_col, mac_rx_dv, phy_tx_en});
    else pass_cnt++;
    reset_n = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (all_outs !== 26'h0) $display("FAIL reset_mid_frame: got %h want 0", all_outs);
    else pass_cnt++;
    mac_tx_en = 1'b0; phy_rx_dv = 1'b0; phy_rx_ce = 1'b0;
    speed_selection = 2'b01;
    @(negedge clk);
    base = rx_cnt;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_cnt++;
    if ({rx_cnt - base, 30'(0), phy_tx_en, mac_rx_dv} !== 64'h0)
      $display("FAIL post_reset_quiet: got bytes=%0d tx_en=%b rx_dv=%b want 0 0 0", rx_cnt - base, phy_tx_en, mac_rx_dv);
    else pass_cnt++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_gig_tx;
    test_half_duplex;
    test_tx_100;
    test_rx_10;
    test_rx_100_misalign;
    test_speed_change;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
